// File: rtl/sparse_pack_pkg.sv
// Shared constants and helpers for the sparse activation packer.
package sparse_pack_pkg;

  localparam int ACT_W_DEF = 4;
  localparam int WIN_DEF   = 8;
  localparam int KEEP_DEF  = 4;

  localparam logic MODE_SPARSE = 1'b0;
  localparam logic MODE_DENSE  = 1'b1;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sparse_lane_mux.sv
// One output lane: WIN:1 activation select with mask, range check and dense override.
module sparse_lane_mux
  import sparse_pack_pkg::*;
#(
  parameter int ACT_W = ACT_W_DEF,
  parameter int WIN   = WIN_DEF,
  parameter int IDX_W = clog2(WIN),
  parameter int LANE  = 0
) (
  input  logic [WIN*ACT_W-1:0] i_win,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic                 i_mask,
  input  logic                 i_mode,
  output logic [ACT_W-1:0]     o_act,
  output logic                 o_err
);

  // One extra bit so WIN itself is representable when WIN is a power of two.
  localparam logic [IDX_W:0] WIN_LIM = (IDX_W + 1)'(WIN);

  logic w_in_range;
  assign w_in_range = ({1'b0, i_idx} < WIN_LIM);

  // Lane select: masked lanes are zero; out-of-range sparse index flags error and outputs zero.
  always_comb begin
    o_act = '0;
    o_err = 1'b0;
    if (i_mask) begin
      if (i_mode == MODE_DENSE) begin
        o_act = i_win[LANE*ACT_W +: ACT_W];
      end else if (!w_in_range) begin
        o_err = 1'b1;
      end else begin
        for (int j = 0; j < WIN; j++) begin
          if (i_idx == IDX_W'(j)) o_act = i_win[j*ACT_W +: ACT_W];
        end
      end
    end
  end

endmodule

// File: rtl/sparse_act_packer.sv
// Handshaked 2-stage elastic packer: S1 holds the raw beat, S2 holds the muxed lanes.
module sparse_act_packer
  import sparse_pack_pkg::*;
#(
  parameter int ACT_W = ACT_W_DEF,
  parameter int WIN   = WIN_DEF,
  parameter int KEEP  = KEEP_DEF,
  parameter int IDX_W = clog2(WIN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIN*ACT_W-1:0]  in_act,
  input  logic [KEEP*IDX_W-1:0] in_idx,
  input  logic [KEEP-1:0]       in_mask,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [KEEP*ACT_W-1:0] out_act,
  output logic [KEEP-1:0]       out_err
);

  logic                  r_vld_p1;
  logic [WIN*ACT_W-1:0]  r_act_p1;
  logic [KEEP*IDX_W-1:0] r_idx_p1;
  logic [KEEP-1:0]       r_mask_p1;
  logic                  r_mode_p1;

  logic                  r_vld_p2;
  logic [KEEP*ACT_W-1:0] r_act_p2;
  logic [KEEP-1:0]       r_err_p2;

  logic                  w_s2_load;
  logic                  w_in_fire;
  logic [KEEP*ACT_W-1:0] w_lane_act;
  logic [KEEP-1:0]       w_lane_err;

  // S2 accepts whenever it is empty or draining; S1 can then refill in the same cycle.
  assign w_s2_load = r_vld_p1 && (!r_vld_p2 || out_ready);
  assign in_ready  = !r_vld_p1 || w_s2_load;
  assign w_in_fire = in_valid && in_ready;

  // ---- Stage S1: register the raw input beat ----
  // S1 capture; data only moves on a transfer so idle cycles do not toggle it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_act_p1  <= '0;
      r_idx_p1  <= '0;
      r_mask_p1 <= '0;
      r_mode_p1 <= MODE_SPARSE;
    end else if (w_in_fire) begin
      r_vld_p1  <= 1'b1;
      r_act_p1  <= in_act;
      r_idx_p1  <= in_idx;
      r_mask_p1 <= in_mask;
      r_mode_p1 <= in_mode;
    end else if (w_s2_load) begin
      r_vld_p1  <= 1'b0;
    end
  end

  // ---- Combinational lane muxes between S1 and S2 ----
  for (genvar k = 0; k < KEEP; k++) begin : g_lane
    sparse_lane_mux #(
      .ACT_W (ACT_W),
      .WIN   (WIN),
      .IDX_W (IDX_W),
      .LANE  (k)
    ) u_mux (
      .i_win  (r_act_p1),
      .i_idx  (r_idx_p1[k*IDX_W +: IDX_W]),
      .i_mask (r_mask_p1[k]),
      .i_mode (r_mode_p1),
      .o_act  (w_lane_act[k*ACT_W +: ACT_W]),
      .o_err  (w_lane_err[k])
    );
  end

  // ---- Stage S2: output register ----
  // S2 capture; holds steady under back-pressure, empties when drained with nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      r_act_p2 <= '0;
      r_err_p2 <= '0;
    end else if (w_s2_load) begin
      r_vld_p2 <= 1'b1;
      r_act_p2 <= w_lane_act;
      r_err_p2 <= w_lane_err;
    end else if (out_ready) begin
      r_vld_p2 <= 1'b0;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_act   = r_act_p2;
  assign out_err   = r_err_p2;

endmodule

// File: tb/tb_sparse_act_packer.sv
// Self-checking bench for sparse_act_packer: directed cases plus a random scoreboard stream.
module tb_sparse_act_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default instance (WIN = 8)
  logic        in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [31:0] in_act;
  logic [11:0] in_idx;
  logic [3:0]  in_mask, out_err;
  logic [15:0] out_act;

  // Non-power-of-two instance (WIN = 6)
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic [23:0] b_in_act;
  logic [11:0] b_in_idx;
  logic [3:0]  b_in_mask, b_out_err;
  logic [15:0] b_out_act;

  sparse_act_packer #(.ACT_W(4), .WIN(8), .KEEP(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_idx(in_idx),
    .in_mask(in_mask), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act), .out_err(out_err)
  );

  sparse_act_packer #(.ACT_W(4), .WIN(6), .KEEP(4)) u_dut6 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_act(b_in_act), .in_idx(b_in_idx),
    .in_mask(b_in_mask), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_act(b_out_act), .out_err(b_out_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference lane rule for 4 lanes of 4 bits, 3-bit indexes; returns {err[3:0], act[15:0]}.
  function automatic logic [19:0] ref_lanes(input logic [127:0] act, input logic [11:0] idx,
                                            input logic [3:0] mask, input logic mode, input int win);
    logic [15:0] o;
    logic [3:0]  e;
    int p;
    o = '0;
    e = '0;
    for (int k = 0; k < 4; k++) begin
      p = int'(idx[k*3 +: 3]);
      if (!mask[k]) begin
        o[k*4 +: 4] = 4'h0;
      end else if (mode) begin
        o[k*4 +: 4] = act[k*4 +: 4];
      end else if (p >= win) begin
        e[k] = 1'b1;
      end else begin
        o[k*4 +: 4] = act[p*4 +: 4];
      end
    end
    return {e, o};
  endfunction

  task automatic idle_a();
    in_valid = 1'b0; in_act = '0; in_idx = '0; in_mask = '0; in_mode = 1'b0;
  endtask

  task automatic drive_a(input logic [31:0] a, input logic [11:0] ix, input logic [3:0] m, input logic md);
    in_valid = 1'b1; in_act = a; in_idx = ix; in_mask = m; in_mode = md;
  endtask

  logic [19:0] exp_q[$];
  logic [19:0] e;
  logic [23:0] t_act [3];
  logic [11:0] t_idx [3];
  logic [3:0]  t_mask[3];
  logic        t_mode[3];
  logic [15:0] t_out [3];
  logic [3:0]  t_err [3];

  initial begin
    rst = 1'b1;
    idle_a();
    out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_act = '0; b_in_idx = '0; b_in_mask = '0; b_in_mode = 1'b0;
    b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("reset out_valid", out_valid, 0);
    chk_eq("reset out_act", out_act, 0);
    chk_eq("reset out_err", out_err, 0);
    chk_eq("reset in_ready", in_ready, 1);
    chk_eq("reset b out_valid", b_out_valid, 0);

    // Sparse basic with exact 2-cycle latency
    @(negedge clk);
    drive_a(32'h87654321, 12'hF50, 4'hF, 1'b0);
    #1 chk_eq("sparse accept", in_ready, 1);
    @(negedge clk); idle_a();
    #1 chk_eq("sparse latency1 valid", out_valid, 0);
    @(negedge clk);
    #1;
    chk_eq("sparse valid", out_valid, 1);
    chk_eq("sparse act", out_act, 32'h8631);
    chk_eq("sparse err", out_err, 0);
    @(negedge clk);
    #1 chk_eq("sparse no dup", out_valid, 0);

    // Dense bypass with mask
    drive_a(32'h87654321, 12'hF50, 4'b1011, 1'b1);
    @(negedge clk); idle_a();
    @(negedge clk);
    #1;
    chk_eq("dense valid", out_valid, 1);
    chk_eq("dense act", out_act, 32'h4021);
    chk_eq("dense err", out_err, 0);
    @(negedge clk);

    // Back-pressure: A dense 4321, B sparse all idx 7 -> 8888, C reversed -> 1234
    out_ready = 1'b0;
    drive_a(32'h87654321, 12'h000, 4'hF, 1'b1);
    #1 chk_eq("bp A accept", in_ready, 1);
    @(negedge clk);
    drive_a(32'h87654321, 12'hFFF, 4'hF, 1'b0);
    #1 chk_eq("bp B accept", in_ready, 1);
    @(negedge clk);
    drive_a(32'h87654321, {3'd0, 3'd1, 3'd2, 3'd3}, 4'hF, 1'b0);
    #1;
    chk_eq("bp full in_ready", in_ready, 0);
    chk_eq("bp hold A valid", out_valid, 1);
    chk_eq("bp hold A act", out_act, 32'h4321);
    @(negedge clk);
    #1;
    chk_eq("bp still full", in_ready, 0);
    chk_eq("bp A stable", out_act, 32'h4321);
    out_ready = 1'b1;
    #1;
    chk_eq("bp C with A drain", in_ready, 1);
    @(negedge clk); idle_a();
    #1;
    chk_eq("bp B valid", out_valid, 1);
    chk_eq("bp B act", out_act, 32'h8888);
    @(negedge clk);
    #1;
    chk_eq("bp C valid", out_valid, 1);
    chk_eq("bp C act", out_act, 32'h1234);
    @(negedge clk);
    #1 chk_eq("bp drained", out_valid, 0);

    // Reset mid-stream with two beats buffered
    out_ready = 1'b0;
    drive_a(32'h87654321, 12'h000, 4'hF, 1'b1);
    @(negedge clk);
    drive_a(32'h87654321, 12'hFFF, 4'hF, 1'b0);
    @(negedge clk);
    idle_a();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_eq("rst mid out_valid", out_valid, 0);
    chk_eq("rst mid out_act", out_act, 0);
    chk_eq("rst mid in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk_eq("rst mid discarded", out_valid, 0);
    end

    // Range errors on the WIN = 6 instance
    t_act[0] = 24'h654321; t_idx[0] = {3'd2, 3'd1, 3'd6, 3'd0}; t_mask[0] = 4'hF;    t_mode[0] = 1'b0;
    t_out[0] = 16'h3201;   t_err[0] = 4'b0010;
    t_act[1] = 24'h654321; t_idx[1] = {3'd7, 3'd7, 3'd0, 3'd5}; t_mask[1] = 4'b0111; t_mode[1] = 1'b0;
    t_out[1] = 16'h0016;   t_err[1] = 4'b0100;
    t_act[2] = 24'h654321; t_idx[2] = 12'hFFF;                  t_mask[2] = 4'hF;    t_mode[2] = 1'b1;
    t_out[2] = 16'h4321;   t_err[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_in_valid = 1'b1; b_in_act = t_act[i]; b_in_idx = t_idx[i];
      b_in_mask = t_mask[i]; b_in_mode = t_mode[i];
      @(negedge clk);
      b_in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk_eq($sformatf("win6 valid %0d", i), b_out_valid, 1);
      chk_eq($sformatf("win6 act %0d", i), b_out_act, t_out[i]);
      chk_eq($sformatf("win6 err %0d", i), b_out_err, t_err[i]);
    end

    // Random stream with scoreboard
    begin
      int sent;
      int cyc;
      int got_n;
      sent = 0; cyc = 0; got_n = 0;
      @(negedge clk);
      while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
        in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        in_act    = $urandom();
        in_idx    = 12'($urandom());
        in_mask   = 4'($urandom());
        in_mode   = 1'($urandom());
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
          got_n++;
          if (exp_q.size() == 0) begin
            chk_eq("rnd unexpected beat", {out_err, out_act}, 20'hFFFFF);
          end else begin
            e = exp_q.pop_front();
            chk_eq("rnd beat", {out_err, out_act}, e);
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(ref_lanes({96'b0, in_act}, in_idx, in_mask, in_mode, 8));
          sent++;
        end
        @(negedge clk);
        cyc++;
      end
      chk_eq("rnd pending beats", exp_q.size(), 0);
      chk_eq("rnd beats out", got_n, 1000);
      idle_a();
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk_eq("rnd no extra", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
